// File: rtl/backprop_pkg.sv
// backprop_pkg: types and constants shared by the backprop start-store reader.
// Revision: 1.0
`default_nettype none

package backprop_pkg;

    localparam int c_IDX_W          = 32;
    localparam int c_DATA_SIZE      = 16;
    localparam int c_SIZE           = 3;
    localparam int c_MAX_LAYER_SIZE = 5;
    localparam int c_WORD_W         = c_DATA_SIZE * c_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [c_WORD_W-1:0] data;
        logic [c_IDX_W-1:0]  address;
        logic [c_IDX_W-1:0]  row;
        logic                last;
    } beat_t;

    function automatic logic [c_IDX_W-1:0] clamp_count(input logic [c_IDX_W-1:0] cnt,
                                                       input logic [c_IDX_W-1:0] lim);
        return (cnt > lim) ? lim : cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/start_store_reader_if.sv
// start_store_reader_if: valid/ready beat stream from the reader to the backprop engine.
// Revision: 1.0
`default_nettype none

interface start_store_reader_if #(
    parameter int WORD_W = 48
) ();
    import backprop_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic [WORD_W-1:0]  out_data;
    logic [c_IDX_W-1:0] out_address;
    logic [c_IDX_W-1:0] out_row;
    logic               out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_address,
        output out_row,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_address,
        input  out_row,
        input  out_last,
        output out_ready
    );

endinterface

`default_nettype wire

// File: rtl/start_store_reader_addr_row_counter.sv
// addr_row_counter: nested row (inner) / address (outer) walk with terminal flag.
// Address direction: START_READER_DESCEND_EN defined -> n-1 down to 0, else 0 up to n-1.
// Revision: 1.0
`default_nettype none

module addr_row_counter
    import backprop_pkg::*;
#(
    parameter int SIZE = c_SIZE
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               load_i,
    input  wire logic               step_i,
    input  wire logic [c_IDX_W-1:0] count_i,
    output logic      [c_IDX_W-1:0] address_o,
    output logic      [c_IDX_W-1:0] row_o,
    output logic                    last_o
);

    localparam logic [c_IDX_W-1:0] c_ROW_MAX = c_IDX_W'(SIZE - 1);
    localparam logic [c_IDX_W-1:0] c_ONE     = c_IDX_W'(1);

    logic [c_IDX_W-1:0] address_q;
    logic [c_IDX_W-1:0] row_q;
    logic [c_IDX_W-1:0] end_addr_q;
    logic [c_IDX_W-1:0] w_top_addr;
    logic               w_row_wrap;

    // An empty job parks at address 0 so nothing below zero is ever presented.
    assign w_top_addr = (count_i == '0) ? '0 : (count_i - c_ONE);
    assign w_row_wrap = (row_q == c_ROW_MAX);
    assign last_o     = w_row_wrap && (address_q == end_addr_q);
    assign address_o  = address_q;
    assign row_o      = row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address_q  <= '0;
            row_q      <= '0;
            end_addr_q <= '0;
        end else if (load_i) begin
            row_q <= '0;
`ifdef START_READER_DESCEND_EN
            address_q  <= w_top_addr;
            end_addr_q <= '0;
`else
            address_q  <= '0;
            end_addr_q <= w_top_addr;
`endif
        end else if (step_i && !last_o) begin
            // Holding on the terminal pair keeps address/row stable after the last load.
            if (w_row_wrap) begin
                row_q <= '0;
`ifdef START_READER_DESCEND_EN
                address_q <= address_q - c_ONE;
`else
                address_q <= address_q + c_ONE;
`endif
            end else begin
                row_q <= row_q + c_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/start_store_reader.sv
// start_store_reader: drains the backprop start store, one (address,row) load per cycle,
// into a one-entry valid/ready output register. Option macro: START_READER_DESCEND_EN.
// Revision: 1.0
`default_nettype none

module start_store_reader
    import backprop_pkg::*;
#(
    parameter int DATA_SIZE      = c_DATA_SIZE,
    parameter int SIZE           = c_SIZE,
    parameter int MAX_LAYER_SIZE = c_MAX_LAYER_SIZE
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      start,
    input  wire logic [c_IDX_W-1:0]        layer_count,
    input  wire logic [c_IDX_W-1:0]        data_set,
    output logic                           busy,
    output logic                           done,
    output logic                           load,
    output logic      [c_IDX_W-1:0]        load_address,
    output logic      [c_IDX_W-1:0]        load_row,
    output logic      [c_IDX_W-1:0]        load_data_set,
    output logic                           reset_counter,
    input  wire logic [DATA_SIZE*SIZE-1:0] load_data,
    start_store_reader_if.master           out_if
);

    state_e             state_q;
    logic               busy_q;
    logic               done_q;
    logic               reset_counter_q;
    logic [c_IDX_W-1:0] data_set_q;

    beat_t              beat_q;
    beat_t              beat_d;
    logic               valid_q;
    logic               valid_d;

    logic [c_IDX_W-1:0] w_count;
    logic [c_IDX_W-1:0] w_addr;
    logic [c_IDX_W-1:0] w_row;
    logic               w_last;
    logic               w_job_accept;
    logic               w_beat_accept;
    logic               w_issue;
    logic               w_capture;

    assign w_count       = clamp_count(layer_count, c_IDX_W'(MAX_LAYER_SIZE));
    assign w_job_accept  = (state_q == ST_IDLE) && start;
    assign w_beat_accept = valid_q && out_if.out_ready;
    assign w_issue       = !valid_q || out_if.out_ready;
    assign w_capture     = (state_q == ST_RUN) && w_issue;

    addr_row_counter #(
        .SIZE (SIZE)
    ) u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (w_job_accept),
        .step_i    (w_capture),
        .count_i   (w_count),
        .address_o (w_addr),
        .row_o     (w_row),
        .last_o    (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            reset_counter_q <= 1'b0;
            data_set_q      <= '0;
        end else begin
            done_q          <= 1'b0;
            reset_counter_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        data_set_q      <= data_set;
                        reset_counter_q <= 1'b1;
                        busy_q          <= 1'b1;
                        if (w_count == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_capture && w_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_beat_accept) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // A capture takes priority over an accept so a same-cycle pair replaces the beat.
    always_comb begin
        beat_d  = beat_q;
        valid_d = valid_q;
        if (w_capture) begin
            valid_d        = 1'b1;
            beat_d.data    = load_data;
            beat_d.address = w_addr;
            beat_d.row     = w_row;
            beat_d.last    = w_last;
        end else if (w_beat_accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            beat_q  <= beat_d;
            valid_q <= valid_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign reset_counter      = reset_counter_q;
    assign load               = w_capture;
    assign load_address       = w_addr;
    assign load_row           = w_row;
    assign load_data_set      = data_set_q;
    assign out_if.out_valid   = valid_q;
    assign out_if.out_data    = beat_q.data;
    assign out_if.out_address = beat_q.address;
    assign out_if.out_row     = beat_q.row;
    assign out_if.out_last    = beat_q.last;

endmodule

`default_nettype wire

// File: tb/tb_start_store_reader.sv
// tb_start_store_reader: table-driven job checks plus reset and empty-job sequences.
// Revision: 1.0
`default_nettype none

module tb_start_store_reader;
    import backprop_pkg::*;

    localparam int c_DS  = 16;
    localparam int c_SZ  = 3;
    localparam int c_MLS = 5;
    localparam int c_W   = c_DS * c_SZ;

`ifdef START_READER_DESCEND_EN
    localparam bit c_DESC = 1'b1;
`else
    localparam bit c_DESC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [31:0]     layer_count;
    logic [31:0]     data_set;
    logic            busy, done, load, reset_counter;
    logic [31:0]     load_address, load_row, load_data_set;
    logic [c_W-1:0]  load_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    start_store_reader_if #(.WORD_W(c_W)) out_if ();

    start_store_reader #(
        .DATA_SIZE      (c_DS),
        .SIZE           (c_SZ),
        .MAX_LAYER_SIZE (c_MLS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .layer_count   (layer_count),
        .data_set      (data_set),
        .busy          (busy),
        .done          (done),
        .load          (load),
        .load_address  (load_address),
        .load_row      (load_row),
        .load_data_set (load_data_set),
        .reset_counter (reset_counter),
        .load_data     (load_data),
        .out_if        (out_if)
    );

    // Store model: product word is a fixed function of (address, row, data_set).
    function automatic logic [c_W-1:0] model_word(input logic [31:0] a, input logic [31:0] r,
                                                  input logic [31:0] ds);
        logic [15:0] h, m, l;
        h = 16'(a * 32'd37 + r);
        m = 16'(ds * 32'd101 + a);
        l = 16'(r * 32'd11) ^ 16'h5a5a;
        return {h, m, l};
    endfunction

    assign load_data = model_word(load_address, load_row, load_data_set);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] lc;
        logic [31:0] ds;
        int          mode;      // 0: ready always high, 1: ready 1,0,0,1 repeating
        bit          poke;      // pulse start mid-job
        int          exp_beats; // hand-clamped n * size
    } job_t;

    task automatic run_job(input job_t j);
        int  n, idx, loads, last_acc, c, ea, er;
        bit  got_done, bad_stall, busy_drop;
        n = j.exp_beats / c_SZ;
        idx = 0; loads = 0; last_acc = -1; c = 0;
        got_done = 0; bad_stall = 0; busy_drop = 0;
        @(negedge clk);
        start = 1'b1; layer_count = j.lc; data_set = j.ds; out_if.out_ready = 1'b1;
        while (!got_done && c < 400) begin
            @(negedge clk);
            start = j.poke && (c == 4);
            if (j.poke) layer_count = 32'd1;
            out_if.out_ready = (j.mode == 0) || (c % 4 == 0) || (c % 4 == 3);
            #1;
            if (c == 0) begin
                check("rc_pulse", 64'(reset_counter), 64'd1);
                check("busy_k1", 64'(busy), 64'd1);
                check("load_k1", 64'(load), 64'(n > 0));
                check("valid_k1", 64'(out_if.out_valid), 64'd0);
                check("done_k1", 64'(done), 64'(n == 0));
            end
            if (c == 1) begin
                check("rc_one_cycle", 64'(reset_counter), 64'd0);
                check("valid_k2", 64'(out_if.out_valid), 64'd1);
            end
            if (load) begin
                loads++;
                if (out_if.out_valid && !out_if.out_ready) bad_stall = 1;
            end
            if (!busy) busy_drop = 1;
            if (out_if.out_valid && out_if.out_ready) begin
                if (idx >= j.exp_beats) begin
                    check("extra_beat", 64'(idx), 64'(j.exp_beats - 1));
                end else begin
                    ea = c_DESC ? (n - 1 - idx / c_SZ) : (idx / c_SZ);
                    er = idx % c_SZ;
                    check("beat_addr", 64'(out_if.out_address), 64'(ea));
                    check("beat_row", 64'(out_if.out_row), 64'(er));
                    check("beat_data", 64'(out_if.out_data), 64'(model_word(32'(ea), 32'(er), j.ds)));
                    check("beat_last", 64'(out_if.out_last), 64'(idx == j.exp_beats - 1));
                end
                last_acc = c;
                idx++;
            end
            if (done) got_done = 1;
            c++;
        end
        start = 1'b0;
        check("done_seen", 64'(got_done), 64'd1);
        check("beat_count", 64'(idx), 64'(j.exp_beats));
        check("load_count", 64'(loads), 64'(j.exp_beats));
        check("stall_load", 64'(bad_stall), 64'd0);
        check("busy_held", 64'(busy_drop), 64'd0);
        check("data_set_latch", 64'(load_data_set), 64'(j.ds));
        check("done_cycle", 64'(c - 1), 64'(last_acc + 1));
        @(negedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        check("valid_after", 64'(out_if.out_valid), 64'd0);
    endtask

    job_t jobs[6];

    initial begin
        int acc, c;
        jobs[0] = '{lc: 32'd2, ds: 32'd1, mode: 0, poke: 1'b0, exp_beats: 6};
        jobs[1] = '{lc: 32'd2, ds: 32'd1, mode: 1, poke: 1'b0, exp_beats: 6};
        jobs[2] = '{lc: 32'd0, ds: 32'd3, mode: 0, poke: 1'b0, exp_beats: 0};
        jobs[3] = '{lc: 32'd9, ds: 32'd2, mode: 0, poke: 1'b1, exp_beats: 15};
        jobs[4] = '{lc: 32'd5, ds: 32'd0, mode: 1, poke: 1'b0, exp_beats: 15};
        jobs[5] = '{lc: 32'd1, ds: 32'd7, mode: 1, poke: 1'b0, exp_beats: 3};

        rst_n = 1'b0; start = 1'b0; layer_count = '0; data_set = '0; out_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_load", 64'(load), 64'd0);
        check("rst_rc", 64'(reset_counter), 64'd0);
        check("rst_valid", 64'(out_if.out_valid), 64'd0);
        check("rst_last", 64'(out_if.out_last), 64'd0);
        check("rst_addr", 64'(load_address), 64'd0);
        check("rst_row", 64'(load_row), 64'd0);
        check("rst_ds", 64'(load_data_set), 64'd0);
        check("rst_data", 64'(out_if.out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_job(jobs[i]);

        // Reset in the middle of a job after four beats have gone out.
        @(negedge clk);
        start = 1'b1; layer_count = 32'd3; data_set = 32'd5; out_if.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = 0; c = 0;
        while (acc < 4 && c < 50) begin
            #1;
            if (out_if.out_valid && out_if.out_ready) acc++;
            c++;
            @(negedge clk);
        end
        check("mid_beats", 64'(acc), 64'd4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(out_if.out_valid), 64'd0);
        check("mid_rst_load", 64'(load), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("post_rst_done", 64'(done), 64'd0);
            check("post_rst_busy", 64'(busy), 64'd0);
        end

        run_job('{lc: 32'd3, ds: 32'd4, mode: 0, poke: 1'b0, exp_beats: 9});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
